// File: rtl/b10_voting_pkg.sv
// Shared types and constants for the b10 voting station.
package b10_voting_pkg;

  localparam int VOTE_W = 4;

  // Controller states; the 3-bit space is fully populated.
  typedef enum logic [2:0] {
    STARTUP  = 3'd0,
    STANDBY  = 3'd1,
    GET_IN   = 3'd2,
    START_TX = 3'd3,
    SEND     = 3'd4,
    TX_2_RX  = 3'd5,
    RECEIVE  = 3'd6,
    RX_2_TX  = 3'd7
  } state_e;

  // Word placed on the link: collected vote scrambled with the peer sign.
  function automatic logic [VOTE_W-1:0] encode_vote(input logic [VOTE_W-1:0] voto,
                                                   input logic [VOTE_W-1:0] sign);
    return voto ^ sign;
  endfunction

endpackage

// File: rtl/b10_voting_station.sv
// Single-station voting controller: optional sign reception, vote
// collection from key/green/red buttons, and handshaked transmission.
module b10_voting_station
  import b10_voting_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              r_button,
  input  logic              g_button,
  input  logic              key,
  input  logic              start,
  input  logic              test,
  input  logic              rts,
  input  logic              rtr,
  input  logic [VOTE_W-1:0] v_in,
  input  logic              __obs,
  output logic              cts,
  output logic              ctr,
  output logic [VOTE_W-1:0] v_out
);

  state_e              state_q, state_d;
  logic [VOTE_W-1:0]   voto_q, voto_d;
  logic [VOTE_W-1:0]   sign_q, sign_d;
  logic                last_g_q, last_g_d;
  logic                last_r_q, last_r_d;
  logic                cts_q, cts_d;
  logic                ctr_q, ctr_d;
  logic [VOTE_W-1:0]   v_out_q, v_out_d;

  // The observation strobe is intentionally functionally inert.
  logic obs_unused;
  assign obs_unused = __obs;

  assign cts   = cts_q;
  assign ctr   = ctr_q;
  assign v_out = v_out_q;

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= STARTUP;
      voto_q   <= 4'b0000;
      sign_q   <= 4'b0000;
      last_g_q <= 1'b0;
      last_r_q <= 1'b0;
      cts_q    <= 1'b0;
      ctr_q    <= 1'b0;
      v_out_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      voto_q   <= voto_d;
      sign_q   <= sign_d;
      last_g_q <= last_g_d;
      last_r_q <= last_r_d;
      cts_q    <= cts_d;
      ctr_q    <= ctr_d;
      v_out_q  <= v_out_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_d  = state_q;
    voto_d   = voto_q;
    sign_d   = sign_q;
    last_g_d = last_g_q;
    last_r_d = last_r_q;
    cts_d    = cts_q;
    ctr_d    = ctr_q;
    v_out_d  = v_out_q;

    case (state_q)
      STARTUP: begin
        voto_d = 4'b0000;
        cts_d  = 1'b0;
        ctr_d  = 1'b0;
        if (test) begin
          state_d = RECEIVE;
        end else begin
          sign_d  = 4'b0000;
          state_d = STANDBY;
        end
      end

      RECEIVE: begin
        if (rts) begin
          sign_d  = v_in;
          ctr_d   = 1'b0;
          state_d = RX_2_TX;
        end else begin
          ctr_d   = 1'b1;
        end
      end

      RX_2_TX: begin
        ctr_d = 1'b0;
        if (!rts) begin
          state_d = STANDBY;
        end else begin
          state_d = RX_2_TX;
        end
      end

      STANDBY: begin
        cts_d = 1'b0;
        if (start) begin
          voto_d   = 4'b0000;
          last_g_d = 1'b0;
          last_r_d = 1'b0;
          state_d  = GET_IN;
        end else begin
          state_d  = STANDBY;
        end
      end

      GET_IN: begin
        if (!start) begin
          state_d = START_TX;
        end else if (key) begin
          // Rising edges (relative to the previous sample) toggle the choice bits.
          voto_d[0] = 1'b1;
          voto_d[1] = voto_q[1] ^ (g_button & ~last_g_q);
          voto_d[2] = voto_q[2] ^ (r_button & ~last_r_q);
          last_g_d  = g_button;
          last_r_d  = r_button;
        end else begin
          // Key withdrawn: discard the partial vote.
          voto_d[2:0] = 3'b000;
          last_g_d    = 1'b0;
          last_r_d    = 1'b0;
        end
      end

      START_TX: begin
        voto_d[3] = voto_q[1] ^ voto_q[2];
        state_d   = SEND;
      end

      SEND: begin
        if (rtr) begin
          v_out_d = encode_vote(voto_q, sign_q);
          cts_d   = 1'b1;
          state_d = TX_2_RX;
        end else begin
          cts_d   = 1'b0;
        end
      end

      TX_2_RX: begin
        if (!rtr) begin
          cts_d   = 1'b0;
          state_d = STANDBY;
        end else begin
          cts_d   = 1'b1;
        end
      end

      default: begin
        state_d = STARTUP;
      end
    endcase
  end

endmodule

// File: tb/tb_b10_voting_station.sv
// Self-checking bench for b10_voting_station: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_b10_voting_station;

  logic       clock = 1'b0;
  logic       reset;
  logic       r_button, g_button, key, start, test, rts, rtr, obs;
  logic [3:0] v_in;
  logic       cts, ctr;
  logic [3:0] v_out;

  int checks = 0;
  int errors = 0;

  b10_voting_station dut (
    .clock    (clock),
    .reset    (reset),
    .r_button (r_button),
    .g_button (g_button),
    .key      (key),
    .start    (start),
    .test     (test),
    .rts      (rts),
    .rtr      (rtr),
    .v_in     (v_in),
    .__obs    (obs),
    .cts      (cts),
    .ctr      (ctr),
    .v_out    (v_out)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // Phases named after the controller's documented states (numeric values
  // are the documented encoding, used only for the state comparison).
  localparam int P_STARTUP = 0, P_STANDBY = 1, P_GET_IN = 2, P_START_TX = 3,
                 P_SEND = 4, P_TX_2_RX = 5, P_RECEIVE = 6, P_RX_2_TX = 7;

  typedef struct {
    int   phase;
    bit   enabled;   // key seen (vote bit 0)
    bit   green;     // green choice (bit 1)
    bit   red;       // red choice (bit 2)
    bit   parity;    // bit 3
    bit   held_g;
    bit   held_r;
    logic [3:0] sign;
    bit   cts;
    bit   ctr;
    logic [3:0] vout;
  } mdl_t;

  localparam mdl_t M_RESET = '{P_STARTUP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               4'b0000, 1'b0, 1'b0, 4'b0000};
  mdl_t m = M_RESET;

  function automatic mdl_t step(mdl_t c);
    mdl_t n = c;
    logic [3:0] word;
    case (c.phase)
      P_STARTUP: begin
        n.enabled = 0; n.green = 0; n.red = 0; n.parity = 0;
        n.cts = 0; n.ctr = 0;
        if (test) n.phase = P_RECEIVE;
        else begin n.sign = 4'b0000; n.phase = P_STANDBY; end
      end
      P_RECEIVE: begin
        if (rts) begin n.sign = v_in; n.ctr = 0; n.phase = P_RX_2_TX; end
        else n.ctr = 1;
      end
      P_RX_2_TX: begin
        n.ctr = 0;
        if (!rts) n.phase = P_STANDBY;
      end
      P_STANDBY: begin
        n.cts = 0;
        if (start) begin
          n.enabled = 0; n.green = 0; n.red = 0; n.parity = 0;
          n.held_g = 0; n.held_r = 0; n.phase = P_GET_IN;
        end
      end
      P_GET_IN: begin
        if (!start) n.phase = P_START_TX;
        else if (key) begin
          n.enabled = 1;
          if (g_button && !c.held_g) n.green = !c.green;
          if (r_button && !c.held_r) n.red = !c.red;
          n.held_g = g_button; n.held_r = r_button;
        end else begin
          n.enabled = 0; n.green = 0; n.red = 0; n.held_g = 0; n.held_r = 0;
        end
      end
      P_START_TX: begin
        n.parity = c.green ^ c.red;
        n.phase = P_SEND;
      end
      P_SEND: begin
        if (rtr) begin
          word = {c.parity, c.red, c.green, c.enabled};
          n.vout = word ^ c.sign;
          n.cts = 1; n.phase = P_TX_2_RX;
        end else n.cts = 0;
      end
      default: begin // P_TX_2_RX
        if (!rtr) begin n.cts = 0; n.phase = P_STANDBY; end
      end
    endcase
    return n;
  endfunction

  // Model advances on the same edges the design responds to.
  always @(posedge clock or negedge reset) begin
    if (!reset) m <= M_RESET;
    else        m <= step(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("model_cts",   {31'd0, cts},   {31'd0, m.cts});
    check("model_ctr",   {31'd0, ctr},   {31'd0, m.ctr});
    check("model_v_out", {28'd0, v_out}, {28'd0, m.vout});
    check("model_state", {29'd0, dut.state_q}, m.phase);
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    r_button = 0; g_button = 0; key = 0; start = 0; test = 0;
    rts = 0; rtr = 0; v_in = 4'b0000; obs = 0;
  endtask

  // From STANDBY: collect a vote, end the session; leaves the design in START_TX.
  task automatic vote(input bit g, input bit r, input bit drop);
    start = 1; key = 1; rtr = 0;
    tick();
    tick();
    g_button = g; r_button = r; obs = 1;
    tick();
    g_button = 0; r_button = 0; obs = 0;
    tick();
    if (drop) begin key = 0; tick(); key = 1; end
    start = 0;
    tick();
  endtask

  task automatic wait_cts(input string name);
    int n = 0;
    while (cts !== 1'b1 && n < 20) begin tick(); n++; end
    check(name, {31'd0, cts}, 32'd1);
  endtask

  task automatic back_to_standby(input string name);
    rtr = 0;
    tick();
    tick();
    check({name, "_cts0"}, {31'd0, cts}, 32'd0);
    check({name, "_standby"}, {29'd0, dut.state_q}, 32'd1);
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    #23;
    check("reset_cts",   {31'd0, cts},   32'd0);
    check("reset_ctr",   {31'd0, ctr},   32'd0);
    check("reset_v_out", {28'd0, v_out}, 32'd0);
    reset = 1;
    tick();
    check("reset_standby", {29'd0, dut.state_q}, 32'd1);

    // Plain vote: green once.
    vote(1, 0, 0);
    rtr = 1;
    wait_cts("plain_cts");
    check("plain_v_out", {28'd0, v_out}, 32'h0000000b);
    back_to_standby("plain");

    // Both buttons in the same cycle.
    vote(1, 1, 0);
    rtr = 1;
    wait_cts("both_cts");
    check("both_v_out", {28'd0, v_out}, 32'h00000007);
    back_to_standby("both");

    // Key removed for one cycle after a green press.
    vote(1, 0, 1);
    rtr = 1;
    wait_cts("keyrm_cts");
    check("keyrm_v_out", {28'd0, v_out}, 32'h00000000);
    back_to_standby("keyrm");

    // Handshake stall in SEND.
    vote(1, 0, 0);
    repeat (12) tick();
    check("stall_cts",   {31'd0, cts},   32'd0);
    check("stall_v_out", {28'd0, v_out}, 32'h00000000);
    check("stall_state", {29'd0, dut.state_q}, 32'd4);
    rtr = 1;
    wait_cts("stall_release_cts");
    check("stall_release_v_out", {28'd0, v_out}, 32'h0000000b);

    // Asynchronous reset in the middle of the handshake.
    #2 reset = 0;
    #1;
    check("async_cts",   {31'd0, cts},   32'd0);
    check("async_v_out", {28'd0, v_out}, 32'd0);
    check("async_state", {29'd0, dut.state_q}, 32'd0);
    idle_inputs();
    test = 1;
    tick();
    reset = 1;
    tick();            // STARTUP -> RECEIVE
    tick();            // ctr raised
    check("recv_ctr1", {31'd0, ctr}, 32'd1);
    rts = 1; v_in = 4'b0101;
    tick();
    check("recv_ctr0", {31'd0, ctr}, 32'd0);
    rts = 0; test = 0;
    tick();
    check("recv_standby", {29'd0, dut.state_q}, 32'd1);
    vote(0, 0, 0);
    rtr = 1;
    wait_cts("recv_vote_cts");
    check("recv_vote_v_out", {28'd0, v_out}, 32'h00000004);
    back_to_standby("recv_vote");

    // Randomized traffic; the per-cycle model comparison does the checking.
    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom_range(0, 9) < 8);
      key      = ($urandom_range(0, 9) < 8);
      g_button = ($urandom_range(0, 9) < 3);
      r_button = ($urandom_range(0, 9) < 3);
      test     = $urandom_range(0, 1);
      rts      = ($urandom_range(0, 9) < 4);
      rtr      = $urandom_range(0, 1);
      v_in     = 4'($urandom_range(0, 15));
      obs      = $urandom_range(0, 1);
      if ($urandom_range(0, 149) == 0) begin
        #1 reset = 0;
        #1 reset = 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
